pe_link_tx: RTL and testbench

Outbound link transmitter for one Nanci mesh processing element (PE). Accepts packed `{addr, data}` words tagged with a direction and drives them onto the left/right/up/down neighbour links. Each word is held for `SORT_CYCLES` cycles, matching the step length of the receiving PE's sort schedule. It is the sending end of the `i_PE_l/r/u/d` links that a PE samples.

---
 rtl/nanci_pkg.sv | 19 +
 rtl/pe_link_tx_if.sv | 40 ++++
 rtl/nanci_fifo.sv | 56 +++++
 rtl/pe_link_tx.sv | 127 ++++++++++++
 tb/tb_pe_link_tx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/nanci_pkg.sv
// Shared definitions for the Nanci mesh PE link logic: direction codes,
// word-width helper and link transmitter FSM states.
package nanci_pkg;

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    function automatic int word_width(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

endpackage

// File: rtl/pe_link_tx_if.sv
// Bundle of the link transmitter's word input handshake, link outputs and status.
interface pe_link_tx_if
    import nanci_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 4
);
    localparam int W = word_width(ADDR_WIDTH, DATA_WIDTH);

    logic [W-1:0]             i_word;
    logic [1:0]               i_dir;
    logic                     i_valid;
    logic                     o_ready;
    logic [W-1:0]             o_PE_l;
    logic [W-1:0]             o_PE_r;
    logic [W-1:0]             o_PE_u;
    logic [W-1:0]             o_PE_d;
    logic                     o_valid_l;
    logic                     o_valid_r;
    logic                     o_valid_u;
    logic                     o_valid_d;
    logic                     o_busy;
    logic [$clog2(DEPTH):0]   o_count;

    modport slave (
        input  i_word, i_dir, i_valid,
        output o_ready, o_PE_l, o_PE_r, o_PE_u, o_PE_d,
        output o_valid_l, o_valid_r, o_valid_u, o_valid_d,
        output o_busy, o_count
    );

    modport master (
        output i_word, i_dir, i_valid,
        input  o_ready, o_PE_l, o_PE_r, o_PE_u, o_PE_d,
        input  o_valid_l, o_valid_r, o_valid_u, o_valid_d,
        input  o_busy, o_count
    );

endinterface

// File: rtl/nanci_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap naturally since DEPTH is a power of two.
module nanci_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_FULL);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pe_link_tx.sv
// Outbound mesh link transmitter: queues {dir, word} entries and holds each
// on its selected neighbour link for SORT_CYCLES cycles.
module pe_link_tx
    import nanci_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 3,
    parameter int SORT_CYCLES = 1,
    parameter int DEPTH       = 4
) (
    input  logic         clk,
    input  logic         rst,
    pe_link_tx_if.slave  bus
);
    localparam int W      = word_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int HOLD_W = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(SORT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic [W+1:0]      w_head;
    logic [1:0]        w_head_dir;
    logic [W-1:0]      w_head_word;
    logic [CNT_W-1:0]  w_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_next;
    logic              w_load;
    logic              w_clear;
    logic [W-1:0]      r_link [4];
    logic [3:0]        r_valid;

    assign w_fifo_push = bus.i_valid && bus.o_ready;
    assign w_fifo_pop  = w_load;
    assign w_head_dir  = w_head[W+1:W];
    assign w_head_word = w_head[W-1:0];

    nanci_fifo #(
        .WIDTH (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_data  ({bus.i_dir, bus.i_word}),
        .i_pop   (w_fifo_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
        end
    end

    // A finished hold pops the next queued word on the same edge, so consecutive words leave no gap.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_load       = 1'b1;
                    w_hold_next  = HOLD_RELOAD;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_hold != '0) begin
                    w_hold_next = r_hold - HOLD_ONE;
                end else if (!w_fifo_empty) begin
                    w_load      = 1'b1;
                    w_hold_next = HOLD_RELOAD;
                end else begin
                    w_clear      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hold_next  = '0;
            end
        endcase
    end

    // The direction demux feeds the output register so every link port is driven straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 4; p++) r_link[p] <= '0;
            r_valid <= '0;
        end else if (w_load) begin
            for (int p = 0; p < 4; p++) r_link[p] <= (w_head_dir == 2'(p)) ? w_head_word : '0;
            r_valid <= 4'b0001 << w_head_dir;
        end else if (w_clear) begin
            for (int p = 0; p < 4; p++) r_link[p] <= '0;
            r_valid <= '0;
        end
    end

    assign bus.o_PE_l    = r_link[DIR_L];
    assign bus.o_PE_r    = r_link[DIR_R];
    assign bus.o_PE_u    = r_link[DIR_U];
    assign bus.o_PE_d    = r_link[DIR_D];
    assign bus.o_valid_l = r_valid[DIR_L];
    assign bus.o_valid_r = r_valid[DIR_R];
    assign bus.o_valid_u = r_valid[DIR_U];
    assign bus.o_valid_d = r_valid[DIR_D];
    assign bus.o_count   = w_count;
    assign bus.o_ready   = !w_fifo_full;
    assign bus.o_busy    = (r_state == ST_SEND) || (w_count != '0);

endmodule

// File: tb/tb_pe_link_tx.sv
// Randomised scoreboard bench for pe_link_tx: each accepted word is given an
// absolute link time slot, and a monitor compares every cycle against it.
module tb_pe_link_tx;
    localparam int AW  = 3;
    localparam int DW  = 3;
    localparam int SC  = 3;
    localparam int DEP = 4;
    localparam int W   = AW + DW;

    typedef struct {
        logic [1:0]   dir;
        logic [W-1:0] word;
        int           push;
        int           start;
    } recT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   monEn = 1'b0;
    int   lastEnd = 0;
    recT  expQ[$];
    recT  cur;
    bit   curVld = 1'b0;

    pe_link_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

    pe_link_tx #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SORT_CYCLES (SC),
        .DEPTH       (DEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [27:0] linkVec();
        return {bus.o_valid_d, bus.o_valid_u, bus.o_valid_r, bus.o_valid_l,
                bus.o_PE_d, bus.o_PE_u, bus.o_PE_r, bus.o_PE_l};
    endfunction

    // Drives one cycle of input; a word counts as sent only if the model says the queue has room.
    task automatic applyStimulus(input bit v, input logic [1:0] d, input logic [W-1:0] w);
        recT r;
        @(negedge clk);
        bus.i_valid = v;
        bus.i_dir   = d;
        bus.i_word  = w;
        if (v && expQ.size() != DEP) begin
            r.dir   = d;
            r.word  = w;
            r.push  = cyc + 1;
            r.start = (cyc + 2 > lastEnd) ? cyc + 2 : lastEnd;
            lastEnd = r.start + SC;
            expQ.push_back(r);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'($urandom), W'($urandom));
    endtask

    task automatic clearModel();
        expQ.delete();
        curVld  = 1'b0;
        lastEnd = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_links"}, 64'(linkVec()), 64'd0);
    endtask

    // Reset asserted part-way through a cycle; the links must clear before the next edge.
    task automatic midCycleReset();
        @(posedge clk);
        #3;
        monEn = 1'b0;
        rst   = 1'b1;
        bus.i_valid = 1'b0;
        #1;
        checkAllZero("async_rst");
        clearModel();
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        monEn = 1'b1;
    endtask

    initial begin : monitor
        int n;
        int pending;
        logic [W-1:0] ep [4];
        logic [3:0]   ev;
        forever begin
            @(posedge clk);
            #1;
            if (monEn) begin
                n = cyc;
                if (curVld && n >= cur.start + SC) curVld = 1'b0;
                if (expQ.size() > 0 && expQ[0].start == n) begin
                    cur    = expQ.pop_front();
                    curVld = 1'b1;
                end
                if (expQ.size() > 0) checkOutput("schedule", 64'(expQ[0].start > n), 64'd1);
                for (int p = 0; p < 4; p++) ep[p] = '0;
                ev = '0;
                if (curVld) begin
                    ep[cur.dir] = cur.word;
                    ev[cur.dir] = 1'b1;
                end
                checkOutput("link", 64'(linkVec()), 64'({ev, ep[3], ep[2], ep[1], ep[0]}));
                checkOutput("onehot",
                    64'($countones({bus.o_valid_d, bus.o_valid_u, bus.o_valid_r, bus.o_valid_l}) <= 1),
                    64'd1);
                pending = 0;
                foreach (expQ[i]) if (expQ[i].push <= n) pending++;
                checkOutput("count", 64'(bus.o_count), 64'(pending));
                checkOutput("ready", 64'(bus.o_ready), 64'(pending != DEP));
                checkOutput("busy", 64'(bus.o_busy), 64'(curVld || pending != 0));
            end
        end
    end

    initial begin : stimulus
        bus.i_valid = 1'b0;
        bus.i_dir   = '0;
        bus.i_word  = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkAllZero("reset");
        checkOutput("reset_count", 64'(bus.o_count), 64'd0);
        checkOutput("reset_ready", 64'(bus.o_ready), 64'd1);
        checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
        rst   = 1'b0;
        monEn = 1'b1;

        applyStimulus(1'b1, 2'd1, 6'b000_010);
        idleCycles(6);

        applyStimulus(1'b1, 2'd0, 6'd1);
        applyStimulus(1'b1, 2'd3, 6'd4);
        idleCycles(9);

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 2'(i), W'(i + 8));
        idleCycles(30);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'(3 - i), W'(i + 20));
        idleCycles(2);
        midCycleReset();
        checkOutput("post_rst_count", 64'(bus.o_count), 64'd0);
        checkOutput("post_rst_ready", 64'(bus.o_ready), 64'd1);
        idleCycles(8);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), W'(i + 1));
        idleCycles(16);

        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 99) < 45), 2'($urandom), W'($urandom));
        idleCycles(30);

        for (int i = 0; i < 200; i++)
            applyStimulus(($urandom_range(0, 99) < 85), 2'($urandom), W'($urandom));
        idleCycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
